// File: rtl/dynamixel_pkg.sv
// Shared Dynamixel Protocol 2.0 definitions.
// Used by the status receiver and the sync-write transmitter: header and
// instruction constants, the receive-parser state enumeration, and the
// CRC-16 (poly 0x8005, init 0, non-reflected) byte-update function.
package dynamixel_pkg;

    localparam logic [7:0] HDR_FF       = 8'hFF;
    localparam logic [7:0] HDR_FD       = 8'hFD;
    localparam logic [7:0] HDR_RSV      = 8'h00;
    localparam logic [7:0] INSTR_STATUS = 8'h55;
    localparam logic [7:0] BROADCAST_ID = 8'hFE;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR2, S_HDR3, S_RSV, S_ID, S_LEN_L,
        S_LEN_H, S_INSTR, S_ERR, S_PARAM, S_CRC_L, S_CRC_H
    } state_t;

    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dynamixel_status_receiver_if.sv
// Result bus of the status receiver.
//   valid       one-cycle pulse, packet accepted
//   crc_error   one-cycle pulse, complete packet with bad CRC
//   id/error/param_count/value  fields of the last accepted packet
//   busy        parser is inside a packet
// master: driven by the receiver; slave: consumer side.
interface dynamixel_status_receiver_if;
    logic        valid;
    logic        crc_error;
    logic [7:0]  id;
    logic [7:0]  error;
    logic [7:0]  param_count;
    logic [31:0] value;
    logic        busy;

    modport master (output valid, crc_error, id, error, param_count, value, busy);
    modport slave  (input  valid, crc_error, id, error, param_count, value, busy);
endinterface

// File: rtl/dynamixel_status_receiver_uart_rx.sv
// 8N1 LSB-first UART byte receiver.
//   clock, reset   rising-edge clock, synchronous active-high reset
//   pin            serial line (idle high), synchronised with two flops
//   byte_received  last good byte
//   done           one-cycle strobe per byte with a valid stop bit
// Bits are sampled near mid-bit; a low stop bit discards the byte.
module uart_rx #(
    parameter int clocks_per_bit = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pin,
    output logic [7:0] byte_received,
    output logic       done
);
    localparam int HALF = (clocks_per_bit - 1) / 2;
    localparam int CW   = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t   st_q, st_d;
    logic [1:0]  sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        done_q, done_d;
    logic        rx;

    assign rx            = sync_q[1];
    assign byte_received = byte_q;
    assign done          = done_q;

    always_comb begin
        st_d    = st_q;
        sync_d  = {sync_q[0], pin};
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        case (st_q)
            R_IDLE: if (!rx) begin
                bit_d = '0;
                // With a one- or two-clock bit there is no later mid-point
                // to re-check the start bit, so go straight to data.
                if (HALF == 0) begin
                    st_d  = R_DATA;
                    cnt_d = CW'(clocks_per_bit - 1);
                end else begin
                    st_d  = R_START;
                    cnt_d = CW'(HALF - 1);
                end
            end
            R_START: if (cnt_q == '0) begin
                st_d  = rx ? R_IDLE : R_DATA;
                cnt_d = CW'(clocks_per_bit - 1);
            end else cnt_d = cnt_q - 1'b1;
            R_DATA: if (cnt_q == '0) begin
                shift_d = {rx, shift_q[7:1]};
                cnt_d   = CW'(clocks_per_bit - 1);
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = R_STOP;
            end else cnt_d = cnt_q - 1'b1;
            R_STOP: if (cnt_q == '0) begin
                st_d = R_IDLE;
                if (rx) begin
                    done_d = 1'b1;
                    byte_d = shift_q;
                end
            end else cnt_d = cnt_q - 1'b1;
            default: st_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q    <= R_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: rtl/dynamixel_status_receiver.sv
// Dynamixel Protocol 2.0 status packet receiver.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   pin           serial receive line
//   bus (master)  valid/crc_error pulses, id/error/param_count/value, busy
// Build macro DYNAMIXEL_CRC_CHECK_EN: when defined the CRC-16 is computed
// and checked; otherwise CRC bytes are consumed unchecked and crc_error is 0.
module dynamixel_status_receiver
    import dynamixel_pkg::*;
#(
    parameter int clocks_per_bit = 1,
    parameter int timeout_clocks = 20 * clocks_per_bit
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    dynamixel_status_receiver_if.master bus
);
    localparam int GW = $clog2(timeout_clocks + 2);

    logic [7:0] rx_byte;
    logic       rx_done;

    uart_rx #(.clocks_per_bit(clocks_per_bit)) u_rx (
        .clock(clock), .reset(reset), .pin(pin),
        .byte_received(rx_byte), .done(rx_done)
    );

    state_t      state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]  id_w_q, id_w_d, err_w_q, err_w_d, len_l_q, len_l_d, cnt_q, cnt_d;
    logic [31:0] val_w_q, val_w_d;
    logic        valid_q, valid_d;
    logic [7:0]  id_q, id_d, error_q, error_d, pc_q, pc_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  pidx;
    logic        crc_ok;

    assign pidx = (len_l_q - 8'd4) - cnt_q;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        id_w_d  = id_w_q;
        err_w_d = err_w_q;
        len_l_d = len_l_q;
        cnt_d   = cnt_q;
        val_w_d = val_w_q;
        valid_d = 1'b0;
        id_d    = id_q;
        error_d = error_q;
        pc_d    = pc_q;
        value_d = value_q;
        if (state_q != S_IDLE) gap_d = rx_done ? '0 : gap_q + 1'b1;
        if (rx_done) begin
            case (state_q)
                S_IDLE:  if (rx_byte == HDR_FF) state_d = S_HDR2;
                S_HDR2:  state_d = (rx_byte == HDR_FF) ? S_HDR3 : S_IDLE;
                S_HDR3:  if (rx_byte == HDR_FD) state_d = S_RSV;
                         else if (rx_byte != HDR_FF) state_d = S_IDLE;
                S_RSV:   state_d = (rx_byte == HDR_RSV) ? S_ID : S_IDLE;
                S_ID:    begin id_w_d = rx_byte; state_d = S_LEN_L; end
                S_LEN_L: begin len_l_d = rx_byte; state_d = S_LEN_H; end
                S_LEN_H: if (rx_byte != 8'h00 || len_l_q < 8'd4) state_d = S_IDLE;
                         else begin cnt_d = len_l_q - 8'd4; state_d = S_INSTR; end
                S_INSTR: state_d = (rx_byte == INSTR_STATUS) ? S_ERR : S_IDLE;
                S_ERR:   begin
                    err_w_d = rx_byte;
                    state_d = (cnt_q == 8'd0) ? S_CRC_L : S_PARAM;
                end
                S_PARAM: begin
                    if (pidx < 8'd4) val_w_d[{pidx[1:0], 3'b000} +: 8] = rx_byte;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_CRC_L;
                end
                S_CRC_L: state_d = S_CRC_H;
                S_CRC_H: begin
                    state_d = S_IDLE;
                    if (crc_ok) begin
                        valid_d = 1'b1;
                        id_d    = id_w_q;
                        error_d = err_w_q;
                        pc_d    = len_l_q - 8'd4;
                        value_d = val_w_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && gap_q >= GW'(timeout_clocks)) begin
            state_d = S_IDLE;
        end
        // Every entry to (and stay in) IDLE starts the next packet clean.
        if (state_d == S_IDLE) begin
            gap_d   = '0;
            cnt_d   = '0;
            val_w_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            id_w_q  <= '0;
            err_w_q <= '0;
            len_l_q <= '0;
            cnt_q   <= '0;
            val_w_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            error_q <= '0;
            pc_q    <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            id_w_q  <= id_w_d;
            err_w_q <= err_w_d;
            len_l_q <= len_l_d;
            cnt_q   <= cnt_d;
            val_w_q <= val_w_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            error_q <= error_d;
            pc_q    <= pc_d;
            value_q <= value_d;
        end
    end

`ifdef DYNAMIXEL_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_l_q, crc_l_d;
    logic        crc_error_q, crc_error_d;

    assign crc_ok = ({rx_byte, crc_l_q} == crc_q);

    always_comb begin
        crc_d       = crc_q;
        crc_l_d     = crc_l_q;
        crc_error_d = rx_done && (state_q == S_CRC_H) && !crc_ok;
        if (state_d == S_IDLE) crc_d = '0;
        // Extra FFs while resyncing in HDR3 are not part of the packet.
        else if (rx_done && state_q inside {S_IDLE, S_HDR2, S_HDR3, S_RSV, S_ID,
                 S_LEN_L, S_LEN_H, S_INSTR, S_ERR, S_PARAM} &&
                 !(state_q == S_HDR3 && state_d == S_HDR3))
            crc_d = crc16_update(crc_q, rx_byte);
        if (rx_done && state_q == S_CRC_L) crc_l_d = rx_byte;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q       <= '0;
            crc_l_q     <= '0;
            crc_error_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            crc_l_q     <= crc_l_d;
            crc_error_q <= crc_error_d;
        end
    end

    assign bus.crc_error = crc_error_q;
`else
    assign crc_ok        = 1'b1;
    assign bus.crc_error = 1'b0;
`endif

    assign bus.valid       = valid_q;
    assign bus.id          = id_q;
    assign bus.error       = error_q;
    assign bus.param_count = pc_q;
    assign bus.value       = value_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_dynamixel_status_receiver.sv
module tb_dynamixel_status_receiver;
    localparam int CPB = 4;
    localparam int TO  = 20 * CPB;
`ifdef DYNAMIXEL_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pin   = 1'b1;
    always #5 clock = ~clock;

    dynamixel_status_receiver_if bus ();

    dynamixel_status_receiver #(.clocks_per_bit(CPB), .timeout_clocks(TO)) dut (
        .clock(clock), .reset(reset), .pin(pin), .bus(bus)
    );

    int errs = 0, checks = 0;
    int nv = 0, nc = 0, nb = 0;
    logic [7:0]  pkt[$];
    logic [7:0]  exp_id = 0, exp_err = 0, exp_pc = 0;
    logic [31:0] exp_val = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) if (!reset) begin
        if (bus.valid) nv++;
        if (bus.crc_error) nc++;
        if (bus.valid && bus.crc_error) nb++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_bits);
        pin = 1'b0; idle(CPB);
        for (int i = 0; i < 8; i++) begin pin = b[i]; idle(CPB); end
        pin = 1'b1; idle(CPB * (1 + gap_bits));
    endtask

    task automatic send_pkt(input int maxgap);
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], int'($urandom_range(maxgap, 0)));
    endtask

    // Bit-serial CRC-16/0x8005 over the whole queue.
    function automatic logic [15:0] crc_of(input int n);
        logic [15:0] c = 16'h0000;
        for (int i = 0; i < n; i++)
            for (int k = 7; k >= 0; k--) begin
                logic fb = c[15] ^ pkt[i][k];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        return c;
    endfunction

    task automatic expect_out(input string tag, input int dv, input int dc, input bit busy_exp);
        chk({tag, "_valid"}, dv, 0);
        chk({tag, "_crcerr"}, dc, 0);
    endtask

    // Send pkt, then compare pulse counts and held outputs against the model.
    task automatic run(input string tag, input bit ev, input bit ec, input int maxgap);
        int v0, c0;
        v0 = nv; c0 = nc;
        send_pkt(maxgap);
        idle(3 * CPB);
        chk({tag, "_valid"}, nv - v0, {31'd0, ev});
        chk({tag, "_crcerr"}, nc - c0, {31'd0, ec});
        chk({tag, "_id"}, bus.id, exp_id);
        chk({tag, "_err"}, bus.error, exp_err);
        chk({tag, "_pc"}, bus.param_count, exp_pc);
        chk({tag, "_val"}, bus.value, exp_val);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic load_ping(input logic [7:0] last);
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55,
               8'h00, 8'h06, 8'h04, 8'h26, 8'h65, last};
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        idle(2);
        chk("rst_valid", bus.valid, 0);
        chk("rst_crcerr", bus.crc_error, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_id", bus.id, 0);
        chk("rst_pc", bus.param_count, 0);
        chk("rst_val", bus.value, 0);

        // Ping reply
        load_ping(8'h5D);
        exp_id = 8'h01; exp_err = 8'h00; exp_pc = 8'd3; exp_val = 32'h00260406;
        run("ping", 1, 0, 2);

        // Read reply, exactly four params
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55,
               8'h00, 8'hA6, 8'h00, 8'h00, 8'h00, 8'h8C, 8'hC0};
        exp_pc = 8'd4; exp_val = 32'h000000A6;
        run("read", 1, 0, 0);

        // Corrupted CRC_H
        load_ping(8'h5E);
        if (!CRC_EN) begin exp_pc = 8'd3; exp_val = 32'h00260406; end
        run("badcrc", !CRC_EN, CRC_EN, 1);

        // Resync on extra FF
        pkt = {8'hFF};
        load_ping(8'h5D);
        pkt.push_front(8'hFF);
        exp_id = 8'h01; exp_err = 8'h00; exp_pc = 8'd3; exp_val = 32'h00260406;
        run("resync", 1, 0, 0);

        // Bad instruction: busy mid-packet, idle after INSTR byte
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00};
        send_pkt(0);
        idle(2);
        chk("instr_busy_mid", bus.busy, 1);
        pkt = {8'h02};
        run("instr", 0, 0, 0);

        // Length below 4, and nonzero LEN_H
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00};
        run("len3", 0, 0, 0);
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h01};
        run("lenh", 0, 0, 0);

        // Stall after ID, then full ping
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01};
        send_pkt(0);
        chk("stall_busy_before", bus.busy, 1);
        idle(TO + 1 + 4);
        chk("stall_busy_after", bus.busy, 0);
        load_ping(8'h5D);
        exp_pc = 8'd3; exp_val = 32'h00260406;
        run("after_stall", 1, 0, 0);

        // Reset mid-packet
        pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07};
        send_pkt(0);
        reset = 1'b1; idle(2); reset = 1'b0; idle(1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_id", bus.id, 0);
        chk("midrst_val", bus.value, 0);
        load_ping(8'h5D);
        exp_id = 8'h01; exp_err = 8'h00; exp_pc = 8'd3; exp_val = 32'h00260406;
        run("after_rst", 1, 0, 0);

        // Randomized packets
        for (int k = 0; k < 24; k++) begin
            logic [7:0] rid, rerr, b;
            logic [15:0] c;
            logic [31:0] v;
            int n, kind;
            rid  = 8'($urandom); rerr = 8'($urandom);
            n    = int'($urandom_range(7, 0));
            kind = int'($urandom_range(7, 0));
            pkt  = {8'hFF, 8'hFF, 8'hFD, 8'h00, rid, 8'(n + 4), 8'h00};
            if (kind == 2) begin
                b = 8'($urandom);
                if (b == 8'h55) b = 8'h01;
                pkt.push_back(b);
                run("rnd_instr", 0, 0, 2);
            end else begin
                pkt.push_back(8'h55);
                pkt.push_back(rerr);
                v = 32'd0;
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    pkt.push_back(b);
                    if (i < 4) v = v | (32'(b) << (8 * i));
                end
                c = crc_of(pkt.size());
                pkt.push_back(c[7:0]);
                pkt.push_back(c[15:8]);
                if (kind < 2) pkt[pkt.size() - 1] = pkt[pkt.size() - 1] ^ (8'd1 << $urandom_range(7, 0));
                if (kind >= 2 || !CRC_EN) begin
                    exp_id = rid; exp_err = rerr; exp_pc = 8'(n); exp_val = v;
                end
                run("rnd_pkt", (kind >= 2) || !CRC_EN, (kind < 2) && CRC_EN, 3);
            end
        end

        chk("never_both", nb, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dynamixel_status_receiver.md
DYNAMIXEL_STATUS_RECEIVER -- requirements
Module: dynamixel_status_receiver

Interface
REQ-001 Parameter clocks_per_bit, default 1: UART bit period in clock cycles; passed unchanged to the receive sub-module.
REQ-002 Parameter timeout_clocks, default 20*clocks_per_bit: maximum gap between received bytes inside a packet.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pin  input  1  serial receive line, idle high, 8N1 LSB-first.
REQ-006 valid  output  1  one-cycle pulse: status packet accepted.
REQ-007 crc_error  output  1  one-cycle pulse: complete packet with CRC mismatch.
REQ-008 id  output  8  packet ID of last accepted packet.
REQ-009 error  output  8  error byte of last accepted packet.
REQ-010 param_count  output  8  number of parameter bytes (length-4) of last accepted packet.
REQ-011 value  output  32  first four parameter bytes, little-endian; unreceived bytes read 0.
REQ-012 busy  output  1  high while any state other than IDLE.

Function
REQ-013 Byte stream SHALL be parsed as Protocol 2.0 status packet: FF FF FD 00, ID, LEN_L, LEN_H, 0x55, ERR, params, CRC_L, CRC_H.
REQ-014 States: IDLE, HDR2, HDR3, RSV, ID, LEN_L, LEN_H, INSTR, ERR, PARAM, CRC_L, CRC_H; advance only on a received-byte strobe.
REQ-015 IDLE: FF -> HDR2, else stay. HDR2: FF -> HDR3, else IDLE. HDR3: FD -> RSV, FF stay HDR3, else IDLE. RSV: 00 -> ID, else IDLE.
REQ-016 LEN_H nonzero or 16-bit length < 4 SHALL abort to IDLE with no output pulse.
REQ-017 INSTR byte not 0x55 SHALL abort to IDLE with no output pulse.
REQ-018 PARAM: a down-counter loaded with length-4 counts parameter bytes; length 4 skips PARAM, going ERR -> CRC_L.
REQ-019 Parameter bytes beyond the fourth are consumed and counted but not stored in value.
REQ-020 CRC-16, polynomial 0x8005, initial 0x0000, non-reflected, SHALL cover every byte from the first FF through the last parameter byte.
REQ-021 On CRC_H strobe: match -> valid pulse and id/error/param_count/value update in the same cycle; mismatch -> crc_error pulse, outputs unchanged; both next cycle from the strobe; return to IDLE.
REQ-022 Outputs id/error/param_count/value SHALL hold until next accepted packet; working copies are internal.
REQ-023 Inter-byte gap exceeding timeout_clocks in any non-IDLE state SHALL force IDLE, no pulse; the gap counter clears on every byte strobe.
REQ-024 valid and crc_error SHALL never assert in the same cycle.
REQ-025 CRC accumulator and param counter SHALL clear on every entry to IDLE.

Reset
REQ-026 reset SHALL force IDLE, valid=0, crc_error=0, busy=0, id=0, error=0, param_count=0, value=0, CRC=0, gap counter=0, and reset the receive sub-module.
REQ-027 Reset asserted mid-packet SHALL discard the packet; a new packet after reset deasserts SHALL be received normally.

Configuration
REQ-028 Macro DYNAMIXEL_CRC_CHECK_EN defined: CRC computed and checked per REQ-020/021.
REQ-029 Macro undefined: CRC bytes consumed but not checked, every complete packet pulses valid, crc_error tied 0, no CRC logic synthesised.

Structure
REQ-030 Package dynamixel_pkg SHALL hold header bytes FF/FD/00, status instruction 0x55, broadcast ID FE, state enumeration, and the crc16 byte-update function, shared with the sync-write transmitter.
REQ-031 One sub-module uart_rx (clocks_per_bit parameter; ports clock, reset, pin, byte_received, done) SHALL perform 2-flop synchronisation, mid-bit sampling, and stop-bit check, discarding bytes with a bad stop bit.

Verification
REQ-032 Ping reply FF FF FD 00 01 07 00 55 00 06 04 26 65 5D -> valid pulse, id=01, error=00, param_count=3, value=0x00260406.
REQ-033 Read reply FF FF FD 00 01 08 00 55 00 A6 00 00 00 8C C0 -> valid, param_count=4, value=0x000000A6.
REQ-034 Same ping with last byte 5E -> crc_error pulse, no valid, outputs keep previous values; with macro undefined -> valid pulse.
REQ-035 Prefix FF FF FF FD 00 then valid ping body -> accepted (resync); INSTR byte 0x02 -> no pulse, busy falls after that byte.
REQ-036 Stall of timeout_clocks+1 after the ID byte, then a full ping -> first packet dropped, second accepted; reset pulsed after LEN_L -> no pulse, next ping accepted.
